// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-stage access engine: access size, signedness,
// the decode-produced request bundle and address-error exception codes.
package mem_access_unit_pkg;

  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic {
    UNSIGNED = 1'b0,
    SIGNED   = 1'b1
  } sign_t;

  typedef struct packed {
    logic                      valid;
    logic                      write;
    sign_t                     sig;
    msize_t                    msize;
    logic [MAX_DATA_WIDTH-1:0] data;
  } memory_args_t;

  typedef enum logic [4:0] {
    EXC_NONE = 5'h00,
    ADEL     = 5'h04,
    ADES     = 5'h05
  } exc_code_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } mau_state_t;

  function automatic logic [3:0] msize_bytes(input msize_t ms);
    case (ms)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus request/response channel between the access engine (master)
// and the memory system (slave).
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    dreq_valid;
  logic                    dreq_write;
  logic [ADDR_WIDTH-1:0]   dreq_addr;
  msize_t                  dreq_size;
  logic [DATA_WIDTH/8-1:0] dreq_strobe;
  logic [DATA_WIDTH-1:0]   dreq_data;
  logic                    dreq_addr_ok;
  logic                    dresp_data_ok;
  logic [DATA_WIDTH-1:0]   dresp_data;

  modport master (
    output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dreq_addr_ok, dresp_data_ok, dresp_data
  );

  modport slave (
    input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dreq_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store strobe and replicated store data,
// plus load extraction with sign or zero extension.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OFFW       = $clog2(NB)
) (
  input  logic [OFFW-1:0]       off_i,
  input  msize_t                msize_i,
  input  sign_t                 sig_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] load_raw_i,
  output logic [NB-1:0]         strobe_o,
  output logic [DATA_WIDTH-1:0] store_lanes_o,
  output logic [DATA_WIDTH-1:0] load_ext_o
);

  logic [3:0]            bytes_s;
  logic [NB-1:0]         base_mask_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] keep_s;
  logic                  msb_s;
  logic                  fill_s;

  // Lane steering for both directions; shifting a mask past its width yields all ones after inversion
  always_comb begin
    bytes_s     = msize_bytes(msize_i);
    base_mask_s = ~({NB{1'b1}} << bytes_s);
    strobe_o    = base_mask_s << off_i;

    case (msize_i)
      MSIZE1:  store_lanes_o = {NB{store_data_i[7:0]}};
      MSIZE2:  store_lanes_o = {(DATA_WIDTH/16){store_data_i[15:0]}};
      MSIZE4:  store_lanes_o = {(DATA_WIDTH/32){store_data_i[31:0]}};
      default: store_lanes_o = store_data_i;
    endcase

    shifted_s = load_raw_i >> {off_i, 3'b000};
    keep_s    = ~({DATA_WIDTH{1'b1}} << {bytes_s, 3'b000});
    case (msize_i)
      MSIZE1:  msb_s = shifted_s[7];
      MSIZE2:  msb_s = shifted_s[15];
      MSIZE4:  msb_s = shifted_s[31];
      default: msb_s = shifted_s[DATA_WIDTH-1];
    endcase
    fill_s     = (sig_i == SIGNED) && msb_s;
    load_ext_o = (shifted_s & keep_s) | (~keep_s & {DATA_WIDTH{fill_s}});
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access engine: accepts one decoded request, checks alignment,
// runs one strobed bus transaction and holds the extended result until consumed.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  memory_args_t          in_args,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  flush,
  mem_access_unit_if.master     bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_exc,
  output exc_code_t             out_exc_code,
  output logic [ADDR_WIDTH-1:0] out_badvaddr
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  mau_state_t            state_q;
  logic                  killed_q, write_q, in_ready_q, out_valid_q, out_exc_q;
  sign_t                 sig_q;
  msize_t                msize_q;
  logic [OFFW-1:0]       off_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  exc_code_t             out_exc_code_q;
  logic [ADDR_WIDTH-1:0] out_badvaddr_q, dreq_addr_q;
  logic                  dreq_valid_q, dreq_write_q;
  msize_t                dreq_size_q;
  logic [NB-1:0]         dreq_strobe_q;
  logic [DATA_WIDTH-1:0] dreq_data_q;

  logic [ADDR_WIDTH-1:0] size_mask_s, aligned_addr_s;
  logic                  misaligned_s, accept_s, drop_s;
  logic [OFFW-1:0]       lane_off_d;
  msize_t                lane_msize_d;
  sign_t                 lane_sig_d;
  logic [NB-1:0]         strobe_s;
  logic [DATA_WIDTH-1:0] store_lanes_s, load_ext_s, result_data_s;
  logic                  unused_data_s;

  assign unused_data_s = ^in_args.data;

  // Accept-time decode; lane steering sees the incoming request in IDLE and the latched one afterwards
  always_comb begin
    size_mask_s    = {{(ADDR_WIDTH-4){1'b0}}, msize_bytes(in_args.msize) - 4'd1};
    aligned_addr_s = in_addr & ~size_mask_s;
    misaligned_s   = ((in_args.msize == MSIZE8) && (DATA_WIDTH < 64)) ||
                     ((ALIGN_CHECK == 1'b1) && ((in_addr & size_mask_s) != {ADDR_WIDTH{1'b0}}));
    accept_s       = in_valid && in_args.valid && !flush;
    drop_s         = killed_q || flush;
    if (state_q == ST_IDLE) begin
      lane_off_d   = aligned_addr_s[OFFW-1:0];
      lane_msize_d = in_args.msize;
      lane_sig_d   = in_args.sig;
    end else begin
      lane_off_d   = off_q;
      lane_msize_d = msize_q;
      lane_sig_d   = sig_q;
    end
    result_data_s = write_q ? {DATA_WIDTH{1'b0}} : load_ext_s;
  end

  mem_access_unit_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .off_i        (lane_off_d),
    .msize_i      (lane_msize_d),
    .sig_i        (lane_sig_d),
    .store_data_i (in_args.data[DATA_WIDTH-1:0]),
    .load_raw_i   (bus.dresp_data),
    .strobe_o     (strobe_s),
    .store_lanes_o(store_lanes_s),
    .load_ext_o   (load_ext_s)
  );

  // Transaction FSM; a request stays on the bus until addr_ok even when flushed (killed_q remembers)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      killed_q       <= 1'b0;
      write_q        <= 1'b0;
      sig_q          <= UNSIGNED;
      msize_q        <= MSIZE1;
      off_q          <= {OFFW{1'b0}};
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_data_q     <= {DATA_WIDTH{1'b0}};
      out_exc_q      <= 1'b0;
      out_exc_code_q <= EXC_NONE;
      out_badvaddr_q <= {ADDR_WIDTH{1'b0}};
      dreq_valid_q   <= 1'b0;
      dreq_write_q   <= 1'b0;
      dreq_addr_q    <= {ADDR_WIDTH{1'b0}};
      dreq_size_q    <= MSIZE1;
      dreq_strobe_q  <= {NB{1'b0}};
      dreq_data_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: if (accept_s) begin
          in_ready_q <= 1'b0;
          write_q    <= in_args.write;
          sig_q      <= in_args.sig;
          msize_q    <= in_args.msize;
          off_q      <= aligned_addr_s[OFFW-1:0];
          killed_q   <= 1'b0;
          out_data_q <= {DATA_WIDTH{1'b0}};
          if (misaligned_s) begin
            state_q        <= ST_HOLD;
            out_valid_q    <= 1'b1;
            out_exc_q      <= 1'b1;
            out_exc_code_q <= in_args.write ? ADES : ADEL;
            out_badvaddr_q <= in_addr;
          end else begin
            state_q        <= ST_ADDR;
            out_exc_q      <= 1'b0;
            out_exc_code_q <= EXC_NONE;
            out_badvaddr_q <= {ADDR_WIDTH{1'b0}};
            dreq_valid_q   <= 1'b1;
            dreq_write_q   <= in_args.write;
            dreq_addr_q    <= aligned_addr_s;
            dreq_size_q    <= in_args.msize;
            dreq_strobe_q  <= strobe_s;
            dreq_data_q    <= in_args.write ? store_lanes_s : {DATA_WIDTH{1'b0}};
          end
        end
        ST_ADDR: begin
          if (bus.dreq_addr_ok) begin
            dreq_valid_q <= 1'b0;
            if (bus.dresp_data_ok && drop_s) begin
              state_q    <= ST_IDLE;
              in_ready_q <= 1'b1;
            end else if (bus.dresp_data_ok) begin
              state_q     <= ST_HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= result_data_s;
            end else begin
              state_q  <= ST_DATA;
              killed_q <= drop_s;
            end
          end else begin
            killed_q <= drop_s;
          end
        end
        ST_DATA: begin
          if (bus.dresp_data_ok && drop_s) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end else if (bus.dresp_data_ok) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
            out_data_q  <= result_data_s;
          end else begin
            killed_q <= drop_s;
          end
        end
        ST_HOLD: if (out_ready || flush) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          in_ready_q   <= 1'b1;
          out_valid_q  <= 1'b0;
          dreq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_exc          = out_exc_q;
  assign out_exc_code     = out_exc_code_q;
  assign out_badvaddr     = out_badvaddr_q;
  assign bus.dreq_valid   = dreq_valid_q;
  assign bus.dreq_write   = dreq_write_q;
  assign bus.dreq_addr    = dreq_addr_q;
  assign bus.dreq_size    = dreq_size_q;
  assign bus.dreq_strobe  = dreq_strobe_q;
  assign bus.dreq_data    = dreq_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with 32- and 64-bit instances sharing
// stimulus; expected results go through a scoreboard queue.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        exc;
    exc_code_t   code;
    logic [31:0] bad;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic in_valid32, in_valid64, flush, out_ready, addr_ok, data_ok, sel64;
  memory_args_t in_args;
  logic [31:0] in_addr;
  logic [63:0] dresp;

  logic in_ready32, out_valid32, out_exc32, in_ready64, out_valid64, out_exc64;
  logic [31:0] out_data32, out_bad32, out_bad64;
  logic [63:0] out_data64;
  exc_code_t out_code32, out_code64;

  mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  mem_access_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  assign bus32.dreq_addr_ok  = addr_ok;
  assign bus32.dresp_data_ok = data_ok;
  assign bus32.dresp_data    = dresp[31:0];
  assign bus64.dreq_addr_ok  = addr_ok;
  assign bus64.dresp_data_ok = data_ok;
  assign bus64.dresp_data    = dresp;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ALIGN_CHECK(1'b1)) dut32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_args(in_args), .in_addr(in_addr), .flush(flush), .bus(bus32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
    .out_exc(out_exc32), .out_exc_code(out_code32), .out_badvaddr(out_bad32)
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ALIGN_CHECK(1'b1)) dut64 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_args(in_args), .in_addr(in_addr), .flush(flush), .bus(bus64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
    .out_exc(out_exc64), .out_exc_code(out_code64), .out_badvaddr(out_bad64)
  );

  logic        obs_in_ready, obs_out_valid, obs_dreq_valid, obs_dreq_write, obs_exc;
  logic [63:0] obs_out_data, obs_dreq_data;
  logic [7:0]  obs_strobe;
  logic [31:0] obs_dreq_addr, obs_bad;
  logic [4:0]  obs_code;
  logic [1:0]  obs_size;

  always_comb begin
    if (sel64) begin
      obs_in_ready = in_ready64; obs_out_valid = out_valid64; obs_exc = out_exc64;
      obs_out_data = out_data64; obs_bad = out_bad64; obs_code = out_code64;
      obs_dreq_valid = bus64.dreq_valid; obs_dreq_write = bus64.dreq_write;
      obs_dreq_data = bus64.dreq_data; obs_strobe = bus64.dreq_strobe;
      obs_dreq_addr = bus64.dreq_addr; obs_size = bus64.dreq_size;
    end else begin
      obs_in_ready = in_ready32; obs_out_valid = out_valid32; obs_exc = out_exc32;
      obs_out_data = {32'h0, out_data32}; obs_bad = out_bad32; obs_code = out_code32;
      obs_dreq_valid = bus32.dreq_valid; obs_dreq_write = bus32.dreq_write;
      obs_dreq_data = {32'h0, bus32.dreq_data}; obs_strobe = {4'h0, bus32.dreq_strobe};
      obs_dreq_addr = bus32.dreq_addr; obs_size = bus32.dreq_size;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int dreq_cycles32 = 0;
  exp_t sb_q[$];

  always @(posedge clk) if (bus32.dreq_valid) dreq_cycles32 <= dreq_cycles32 + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic e, input exc_code_t c, input logic [31:0] b);
    exp_t x;
    x.data = d; x.exc = e; x.code = c; x.bad = b;
    sb_q.push_back(x);
  endtask

  task automatic issue(input bit is64, input logic wr, input sign_t sg, input msize_t ms,
                       input logic [63:0] d, input logic [31:0] a);
    sel64   = is64;
    in_args = '{valid: 1'b1, write: wr, sig: sg, msize: ms, data: d};
    in_addr = a;
    if (is64) in_valid64 = 1'b1;
    else      in_valid32 = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
    in_args.valid = 1'b0;
  endtask

  task automatic bus_resp(input int data_delay, input logic [63:0] rd);
    addr_ok = 1'b1;
    if (data_delay == 0) begin data_ok = 1'b1; dresp = rd; end
    @(negedge clk);
    addr_ok = 1'b0;
    data_ok = 1'b0;
    if (data_delay > 0) begin
      repeat (data_delay - 1) @(negedge clk);
      data_ok = 1'b1;
      dresp   = rd;
      @(negedge clk);
      data_ok = 1'b0;
    end
  endtask

  task automatic get_result(input string tag, input int budget);
    exp_t e;
    int   i = 0;
    while (!obs_out_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_out_valid"}, obs_out_valid, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_data"}, obs_out_data, e.data);
      check({tag, "_exc"}, obs_exc, e.exc);
      check({tag, "_code"}, obs_code, e.code);
      check({tag, "_badvaddr"}, obs_bad, e.bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, obs_in_ready, 1);
    check({tag, "_out_valid_after"}, obs_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    in_valid32 = 1'b0; in_valid64 = 1'b0; flush = 1'b0; out_ready = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; sel64 = 1'b0; dresp = 64'h0;
    in_args = '0; in_addr = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", obs_in_ready, 1);
    check("rst_out_valid", obs_out_valid, 0);
    check("rst_dreq_valid", obs_dreq_valid, 0);
    check("rst_out_data", obs_out_data, 0);
    resetn = 1'b1;
    @(negedge clk);

    // SW with addr_ok and data_ok together
    issue(1'b0, 1'b1, UNSIGNED, MSIZE4, 64'h1234_5678, 32'h100);
    push(64'h0, 1'b0, EXC_NONE, 32'h0);
    check("sw_in_ready", obs_in_ready, 0);
    check("sw_dreq_valid", obs_dreq_valid, 1);
    check("sw_strobe", obs_strobe, 8'h0F);
    check("sw_dreq_data", obs_dreq_data, 64'h1234_5678);
    check("sw_dreq_addr", obs_dreq_addr, 32'h100);
    check("sw_dreq_write", obs_dreq_write, 1);
    bus_resp(0, 64'h0);
    check("sw_latency", obs_out_valid, 1);
    get_result("sw", 4);

    issue(1'b0, 1'b0, SIGNED, MSIZE1, 64'h0, 32'h103);
    push(64'hFFFF_FF80, 1'b0, EXC_NONE, 32'h0);
    check("lb_strobe", obs_strobe, 8'h08);
    bus_resp(1, 64'h80FF_FFFF);
    get_result("lb", 4);

    issue(1'b0, 1'b0, UNSIGNED, MSIZE1, 64'h0, 32'h103);
    push(64'h0000_0080, 1'b0, EXC_NONE, 32'h0);
    bus_resp(1, 64'h80FF_FFFF);
    get_result("lbu", 4);

    c = dreq_cycles32;
    issue(1'b0, 1'b0, SIGNED, MSIZE2, 64'h0, 32'h101);
    push(64'h0, 1'b1, ADEL, 32'h101);
    check("lh_mis_latency", obs_out_valid, 1);
    get_result("lh_mis", 2);
    check("lh_mis_no_bus", dreq_cycles32, c);

    issue(1'b0, 1'b1, UNSIGNED, MSIZE2, 64'hBEEF, 32'h102);
    push(64'h0, 1'b0, EXC_NONE, 32'h0);
    check("sh_strobe", obs_strobe, 8'h0C);
    check("sh_data_hi", obs_dreq_data[31:16], 16'hBEEF);
    bus_resp(0, 64'h0);
    get_result("sh", 4);

    issue(1'b0, 1'b1, UNSIGNED, MSIZE4, 64'h1, 32'h102);
    push(64'h0, 1'b1, ADES, 32'h102);
    get_result("sw_mis", 2);

    issue(1'b0, 1'b0, SIGNED, MSIZE2, 64'h0, 32'h106);
    push(64'hFFFF_8001, 1'b0, EXC_NONE, 32'h0);
    bus_resp(0, 64'h8001_1234);
    get_result("lh", 4);

    issue(1'b0, 1'b0, UNSIGNED, MSIZE2, 64'h0, 32'h106);
    push(64'h0000_8001, 1'b0, EXC_NONE, 32'h0);
    bus_resp(0, 64'h8001_1234);
    get_result("lhu", 4);

    // addr_ok withheld: request must stay put
    issue(1'b0, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h200);
    push(64'hDEAD_BEEF, 1'b0, EXC_NONE, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", obs_dreq_valid, 1);
      check("stall_addr", obs_dreq_addr, 32'h200);
      check("stall_strobe", obs_strobe, 8'h0F);
      check("stall_size", obs_size, MSIZE4);
      @(negedge clk);
    end
    bus_resp(2, 64'hDEAD_BEEF);
    get_result("lw_stall", 4);

    // flush while waiting for data
    issue(1'b0, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h300);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fdata_dreq_low", obs_dreq_valid, 0);
    @(negedge clk);
    data_ok = 1'b1; dresp = 64'h1111_2222;
    @(negedge clk);
    data_ok = 1'b0;
    check("fdata_in_ready", obs_in_ready, 1);
    check("fdata_out_valid", obs_out_valid, 0);
    repeat (2) @(negedge clk);
    check("fdata_still_idle", obs_out_valid, 0);

    // flush while request is pending on the bus
    issue(1'b0, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h310);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("faddr_dreq_held", obs_dreq_valid, 1);
    check("faddr_dreq_addr", obs_dreq_addr, 32'h310);
    addr_ok = 1'b1; data_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b0;
    check("faddr_in_ready", obs_in_ready, 1);
    check("faddr_out_valid", obs_out_valid, 0);

    // flush in the accept cycle
    in_args = '{valid: 1'b1, write: 1'b0, sig: SIGNED, msize: MSIZE4, data: 64'h0};
    in_addr = 32'h320; in_valid32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid32 = 1'b0; flush = 1'b0;
    check("facc_in_ready", obs_in_ready, 1);
    check("facc_dreq_valid", obs_dreq_valid, 0);

    // flush in HOLD drops the result
    issue(1'b0, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h324);
    bus_resp(0, 64'h5555_AAAA);
    check("fhold_valid", obs_out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fhold_dropped", obs_out_valid, 0);
    check("fhold_in_ready", obs_in_ready, 1);

    // 64-bit access size on a 32-bit bus
    issue(1'b0, 1'b0, SIGNED, MSIZE8, 64'h0, 32'h100);
    push(64'h0, 1'b1, ADEL, 32'h100);
    get_result("ld32_exc", 2);

    // reset while in DATA
    issue(1'b0, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h330);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rdata_dreq_valid", obs_dreq_valid, 0);
    check("rdata_out_valid", obs_out_valid, 0);
    check("rdata_in_ready", obs_in_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    data_ok = 1'b1; dresp = 64'h7777_7777;
    @(negedge clk);
    data_ok = 1'b0;
    @(negedge clk);
    check("rdata_late_ok", obs_out_valid, 0);
    check("rdata_late_ready", obs_in_ready, 1);

    // 64-bit instance
    issue(1'b1, 1'b0, SIGNED, MSIZE4, 64'h0, 32'h104);
    push(64'hFFFF_FFFF_8765_4321, 1'b0, EXC_NONE, 32'h0);
    check("lw64_strobe", obs_strobe, 8'hF0);
    bus_resp(0, 64'h8765_4321_0000_0000);
    get_result("lw64", 4);

    issue(1'b1, 1'b0, SIGNED, MSIZE8, 64'h0, 32'h108);
    push(64'h0123_4567_89AB_CDEF, 1'b0, EXC_NONE, 32'h0);
    check("ld64_strobe", obs_strobe, 8'hFF);
    bus_resp(1, 64'h0123_4567_89AB_CDEF);
    get_result("ld64", 4);

    issue(1'b1, 1'b1, UNSIGNED, MSIZE1, 64'hA5, 32'h10D);
    push(64'h0, 1'b0, EXC_NONE, 32'h0);
    check("sb64_strobe", obs_strobe, 8'h20);
    check("sb64_lane", obs_dreq_data[47:40], 8'hA5);
    bus_resp(0, 64'h0);
    get_result("sb64", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
